// File: rtl/nn_layer_sequencer.sv
// Sequences NUM_LAYERS matrix-multiply layers (ReLU between them, argmax at the end) for one inference.
// Engine launch pulses are registered on stage entry; the optional stage watchdog is compiled in by NNSEQ_STAGE_TIMEOUT_EN.
module nn_layer_sequencer #(
   parameter int NUM_LAYERS     = 4,
   parameter int DIM_W          = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        data_ready,
   input  logic [NUM_LAYERS*DIM_W-1:0] cfg_k,
   input  logic [NUM_LAYERS*DIM_W-1:0] cfg_n,
   input  logic                        mm_done,
   input  logic                        relu_done,
   input  logic                        argmax_done,
   output logic                        mm_start,
   output logic                        relu_start,
   output logic                        argmax_start,
   output logic [DIM_W-1:0]            cur_k,
   output logic [DIM_W-1:0]            cur_n,
   output logic [2:0]                  layer_idx,
   output logic [2:0]                  state,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [31:0]                 cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_MM      = 3'd2,
      S_RELU    = 3'd3,
      S_ARGMAX  = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  layer_idx_q, layer_idx_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        mm_start_q, relu_start_q, argmax_start_q;
   logic        busy_w;
   logic        last_layer;
   logic        restart;
   logic        wd_expired;

   assign busy_w     = (state_q == S_WAIT) || (state_q == S_MM) ||
                       (state_q == S_RELU) || (state_q == S_ARGMAX);
   assign last_layer = (layer_idx_q >= 3'(NUM_LAYERS - 1));
   assign restart    = (state_d == S_WAIT) && ((state_q == S_IDLE) || (state_q == S_ERROR));

`ifdef NNSEQ_STAGE_TIMEOUT_EN
   logic [31:0] wd_q;

   // Counts cycles in the current stage; any state change restarts it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_q <= 32'd0;
      end else if (state_d != state_q) begin
         wd_q <= 32'd0;
      end else if (busy_w && (wd_q != 32'hFFFF_FFFF)) begin
         wd_q <= wd_q + 32'd1;
      end
   end

   assign wd_expired = busy_w && (wd_q == 32'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign wd_expired     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a done input is ignored during its own launch cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_WAIT;
         S_WAIT:   if (data_ready) state_d = S_MM;
         S_MM:     if (mm_done && !mm_start_q) state_d = last_layer ? S_ARGMAX : S_RELU;
         S_RELU:   if (relu_done && !relu_start_q) state_d = S_MM;
         S_ARGMAX: if (argmax_done && !argmax_start_q) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
`ifdef NNSEQ_STAGE_TIMEOUT_EN
         S_ERROR: begin
            if (start) begin
               state_d = S_WAIT;
            end else if (abort) begin
               state_d = S_IDLE;
            end
         end
`endif
         default:  state_d = S_IDLE;
      endcase
      if (wd_expired && (state_d == state_q)) begin
         state_d = S_ERROR;
      end
      if (busy_w && abort) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      layer_idx_d   = layer_idx_q;
      cycle_count_d = cycle_count_q;
      if (restart) begin
         layer_idx_d   = 3'd0;
         cycle_count_d = 32'd0;
      end else begin
         if ((state_q == S_RELU) && (state_d == S_MM)) begin
            layer_idx_d = layer_idx_q + 3'd1;
         end
         // The abort cycle itself is not counted, so the value freezes at the last busy cycle.
         if (busy_w && !abort && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         layer_idx_q    <= 3'd0;
         cycle_count_q  <= 32'd0;
         mm_start_q     <= 1'b0;
         relu_start_q   <= 1'b0;
         argmax_start_q <= 1'b0;
      end else begin
         layer_idx_q    <= layer_idx_d;
         cycle_count_q  <= cycle_count_d;
         mm_start_q     <= (state_d == S_MM)     && (state_q != S_MM);
         relu_start_q   <= (state_d == S_RELU)   && (state_q != S_RELU);
         argmax_start_q <= (state_d == S_ARGMAX) && (state_q != S_ARGMAX);
      end
   end

   // Output logic
   always_comb begin
      state        = state_q;
      busy         = busy_w;
      done         = (state_q == S_DONE);
`ifdef NNSEQ_STAGE_TIMEOUT_EN
      error        = (state_q == S_ERROR);
`else
      error        = 1'b0;
`endif
      mm_start     = mm_start_q;
      relu_start   = relu_start_q;
      argmax_start = argmax_start_q;
      layer_idx    = layer_idx_q;
      cycle_count  = cycle_count_q;
      cur_k        = '0;
      cur_n        = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (layer_idx_q == 3'(i)) begin
            cur_k = cfg_k[i*DIM_W +: DIM_W];
            cur_n = cfg_n[i*DIM_W +: DIM_W];
         end
      end
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: expected engine-event sequence per inference, hand-computed cycle counts, NUM_LAYERS=1 instance.
module tb_nn_layer_sequencer;
   localparam int NL = 4;
   localparam int DW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn, start, abort, data_ready;
   logic [NL*DW-1:0] cfg_k, cfg_n;
   logic mm_done_r, relu_done_r, argmax_done_r;
   logic mm_done_x, relu_done_x, argmax_done_x;
   logic mm_done, relu_done, argmax_done;
   logic mm_start, relu_start, argmax_start;
   logic [DW-1:0] cur_k, cur_n;
   logic [2:0] layer_idx, state;
   logic busy, done, error;
   logic [31:0] cycle_count;

   assign mm_done     = mm_done_r | mm_done_x;
   assign relu_done   = relu_done_r | relu_done_x;
   assign argmax_done = argmax_done_r | argmax_done_x;

   nn_layer_sequencer #(.NUM_LAYERS(NL), .DIM_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .data_ready(data_ready),
      .cfg_k(cfg_k), .cfg_n(cfg_n),
      .mm_done(mm_done), .relu_done(relu_done), .argmax_done(argmax_done),
      .mm_start(mm_start), .relu_start(relu_start), .argmax_start(argmax_start),
      .cur_k(cur_k), .cur_n(cur_n), .layer_idx(layer_idx), .state(state),
      .busy(busy), .done(done), .error(error), .cycle_count(cycle_count)
   );

   logic start1, abort1, mm_done1, relu_done1, argmax_done1;
   logic [DW-1:0] cfg_k1, cfg_n1, cur_k1, cur_n1;
   logic mm_start1, relu_start1, argmax_start1, busy1, done1, error1;
   logic [2:0] layer_idx1, state1;
   logic [31:0] cycle_count1;

   nn_layer_sequencer #(.NUM_LAYERS(1), .DIM_W(DW), .TIMEOUT_CYCLES(16)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1), .abort(abort1), .data_ready(data_ready),
      .cfg_k(cfg_k1), .cfg_n(cfg_n1),
      .mm_done(mm_done1), .relu_done(relu_done1), .argmax_done(argmax_done1),
      .mm_start(mm_start1), .relu_start(relu_start1), .argmax_start(argmax_start1),
      .cur_k(cur_k1), .cur_n(cur_n1), .layer_idx(layer_idx1), .state(state1),
      .busy(busy1), .done(done1), .error(error1), .cycle_count(cycle_count1)
   );

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int start_cyc = 0;
   int kcfg[NL];
   int ncfg[NL];
   int exp_q[$];
   bit resp_en;
   int relu1_cnt = 0;
   int mm1_cnt = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Engine models: each done returned 3 cycles after its launch pulse.
   initial begin
      mm_done_r = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (resp_en && mm_start) begin
            repeat (3) @(posedge clk);
            #1 mm_done_r = 1'b1;
            @(posedge clk); #1 mm_done_r = 1'b0;
         end
      end
   end
   initial begin
      relu_done_r = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (resp_en && relu_start) begin
            repeat (3) @(posedge clk);
            #1 relu_done_r = 1'b1;
            @(posedge clk); #1 relu_done_r = 1'b0;
         end
      end
   end
   initial begin
      argmax_done_r = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (resp_en && argmax_start) begin
            repeat (3) @(posedge clk);
            #1 argmax_done_r = 1'b1;
            @(posedge clk); #1 argmax_done_r = 1'b0;
         end
      end
   end

   // Event codes: MM of layer i = i, RELU after layer i = 10+i, ARGMAX = 20, DONE = 30.
   always @(negedge clk) begin : cmp
      int np, ev, e;
      np = int'(mm_start) + int'(relu_start) + int'(argmax_start) + int'(done);
      if (np != 0) begin
         chk("single_pulse", np, 1);
         ev = mm_start ? int'(layer_idx) : relu_start ? 10 + int'(layer_idx) : argmax_start ? 20 : 30;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", ev, -1);
         end else begin
            e = exp_q.pop_front();
            chk("event", ev, e);
            if ((mm_start || relu_start) && (e < 20)) begin
               chk("cur_k", cur_k, kcfg[e % 10]);
               chk("cur_n", cur_n, ncfg[e % 10]);
            end
            if (done) chk("done_cycle_count", cycle_count, cyc - start_cyc);
         end
      end
`ifndef NNSEQ_STAGE_TIMEOUT_EN
      chk("error_low", error, 0);
`endif
   end

   always @(negedge clk) begin
      if (relu_start1) relu1_cnt++;
      if (mm_start1) mm1_cnt++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_cfg();
      for (int i = 0; i < NL; i++) begin
         cfg_k[i*DW +: DW] = DW'(kcfg[i]);
         cfg_n[i*DW +: DW] = DW'(ncfg[i]);
      end
   endtask

   task automatic push_inf(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(i);
         if (i < n - 1) exp_q.push_back(10 + i);
      end
      exp_q.push_back(20);
      exp_q.push_back(30);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_state(input int st, input string nm);
      for (int i = 0; i < 200; i++) begin
         if (int'(state) == st) break;
         tick();
      end
      chk(nm, state, st);
   endtask

   task automatic finish_stage(input int which);
      tick();
      if (which == 0) mm_done_x = 1'b1; else relu_done_x = 1'b1;
      tick();
      mm_done_x = 1'b0;
      relu_done_x = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish before %0d", cyc);
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; data_ready = 1'b0; resp_en = 1'b1;
      mm_done_x = 1'b0; relu_done_x = 1'b0; argmax_done_x = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; mm_done1 = 1'b0; relu_done1 = 1'b0; argmax_done1 = 1'b0;
      cfg_k1 = 10'd500; cfg_n1 = 10'd3;
      kcfg = '{784, 64, 64, 32};
      ncfg = '{64, 64, 32, 10};
      set_cfg();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_layer", layer_idx, 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_done", done, 0);
      chk("rst_mm_start", mm_start, 0);
      resetn = 1'b1;
      tick();
      chk("idle_after_reset", state, 0);

      // Happy path: WAIT 1 cycle + 8 stages of 4 cycles = 33 busy cycles.
      data_ready = 1'b1;
      push_inf(4);
      do_start();
      wait_state(5, "happy_done");
      chk("happy_cycles", cycle_count, 33);
      chk("happy_done_pulse", done, 1);
      tick();
      chk("happy_idle", state, 0);
      chk("happy_layer_held", layer_idx, 3);
      chk("happy_drained", exp_q.size(), 0);

      // Delayed data_ready and new dimensions: MM entered 6 cycles after start, so 38 busy cycles.
      kcfg = '{100, 200, 300, 5};
      ncfg = '{7, 8, 9, 1023};
      set_cfg();
      data_ready = 1'b0;
      push_inf(4);
      do_start();
      repeat (5) tick();
      chk("wait_hold", state, 1);
      data_ready = 1'b1;
      wait_state(5, "delayed_done");
      chk("delayed_cycles", cycle_count, 38);
      tick();
      chk("delayed_drained", exp_q.size(), 0);

      // Spurious inputs in MM, then abort together with mm_done in layer 2.
      resp_en = 1'b0;
      exp_q.push_back(0); exp_q.push_back(10); exp_q.push_back(1);
      exp_q.push_back(11); exp_q.push_back(2);
      do_start();
      wait_state(2, "mm0");
      tick();
      start = 1'b1; relu_done_x = 1'b1;
      tick();
      start = 1'b0; relu_done_x = 1'b0;
      chk("spurious_hold", state, 2);
      chk("spurious_layer", layer_idx, 0);
      finish_stage(0);
      wait_state(3, "relu0");
      finish_stage(1);
      wait_state(2, "mm1");
      finish_stage(0);
      wait_state(3, "relu1");
      finish_stage(1);
      wait_state(2, "mm2");
      chk("abort_layer", layer_idx, 2);
      tick();
      mm_done_x = 1'b1; abort = 1'b1;
      tick();
      mm_done_x = 1'b0; abort = 1'b0;
      chk("abort_idle", state, 0);
      chk("abort_count", cycle_count, 12);
      repeat (3) tick();
      chk("abort_count_frozen", cycle_count, 12);
      chk("abort_layer_held", layer_idx, 2);
      chk("abort_drained", exp_q.size(), 0);
      resp_en = 1'b1;

      // Single-layer instance: MM then ARGMAX directly.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("n1_wait", state1, 1);
      tick();
      chk("n1_mm", state1, 2);
      chk("n1_mm_start", mm_start1, 1);
      chk("n1_cur_k", cur_k1, 500);
      chk("n1_cur_n", cur_n1, 3);
      tick();
      mm_done1 = 1'b1;
      tick();
      mm_done1 = 1'b0;
      chk("n1_argmax", state1, 4);
      chk("n1_argmax_start", argmax_start1, 1);
      tick();
      argmax_done1 = 1'b1;
      tick();
      argmax_done1 = 1'b0;
      chk("n1_done", done1, 1);
      chk("n1_done_state", state1, 5);
      chk("n1_cycles", cycle_count1, 5);
      tick();
      chk("n1_idle", state1, 0);
      chk("n1_done_low", done1, 0);
      chk("n1_no_relu", relu1_cnt, 0);
      chk("n1_one_mm", mm1_cnt, 1);

      // Reset asserted in the first cycle of RELU.
      push_inf(4);
      do_start();
      wait_state(3, "relu_pre_reset");
      #1 resetn = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_layer", layer_idx, 0);
      chk("arst_count", cycle_count, 0);
      chk("arst_relu_start", relu_start, 0);
      chk("arst_mm_start", mm_start, 0);
      chk("arst_done", done, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (8) tick();
      chk("idle_after_release", state, 0);

`ifdef NNSEQ_STAGE_TIMEOUT_EN
      resp_en = 1'b0;
      exp_q.push_back(0);
      do_start();
      wait_state(2, "to_mm");
      repeat (15) tick();
      chk("pre_timeout_state", state, 2);
      tick();
      chk("timeout_state", state, 6);
      chk("timeout_error", error, 1);
      data_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("error_restart_state", state, 1);
      chk("error_cleared", error, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("error_abort_idle", state, 0);
      resp_en = 1'b1;
`endif

      repeat (2) tick();
      chk("final_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of MM layers run per inference (legal range 1..8).
REQ-002 SHALL have parameter DIM_W, default 10, width of each layer dimension field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum cycles spent waiting in any one stage (used only with the REQ-030 macro).
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request one inference
- abort  in  1  cancel the current inference
- data_ready  in  1  input vector is loaded and valid
- cfg_k  in  NUM_LAYERS*DIM_W  input length per layer; layer i occupies bits [i*DIM_W +: DIM_W]
- cfg_n  in  NUM_LAYERS*DIM_W  output length per layer; same packing as cfg_k
- mm_done, relu_done, argmax_done  in  1 each  completion pulses from the engines
- mm_start, relu_start, argmax_start  out  1 each  one-cycle launch pulses to the engines
- cur_k, cur_n  out  DIM_W each  dimensions of the active layer
- layer_idx  out  3  index of the active layer
- state  out  3  FSM state encoding
- busy  out  1  high when state is not IDLE, DONE or ERROR
- done  out  1  one-cycle pulse when an inference completes
- error  out  1  set when a stage times out
- cycle_count  out  32  cycles spent on the last inference

Function
REQ-005 SHALL implement states IDLE=0, WAIT_DATA=1, MM=2, RELU=3, ARGMAX=4, DONE=5, ERROR=6.
REQ-006 SHALL move IDLE->WAIT_DATA on start=1, setting layer_idx=0 and clearing cycle_count.
REQ-007 SHALL move WAIT_DATA->MM on the first cycle with data_ready=1.
REQ-008 SHALL register every engine start pulse so that it is high for exactly the first cycle of the state it launches: mm_start on entry to MM, relu_start on entry to RELU, argmax_start on entry to ARGMAX.
REQ-009 SHALL ignore a done input in the same cycle as its start pulse, and whenever the FSM is not in the matching state.
REQ-010 SHALL, in MM on mm_done, go to RELU if layer_idx<NUM_LAYERS-1, and go to ARGMAX otherwise; the last layer skips ReLU.
REQ-011 SHALL, in RELU on relu_done, increment layer_idx and go to MM.
REQ-012 SHALL, in ARGMAX on argmax_done, go to DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-013 SHALL drive cur_k and cur_n combinationally from the cfg_k and cfg_n fields selected by layer_idx.
REQ-014 SHALL hold layer_idx at its final value in IDLE, DONE and ERROR.
REQ-015 SHALL increment cycle_count once per cycle while busy=1, and freeze it at DONE, ERROR or abort, saturating at 32'hFFFFFFFF.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL, on abort=1 in any busy state, go to IDLE next cycle with no done pulse and no further start pulses; abort SHALL override a done input arriving in the same cycle.
REQ-018 SHALL ignore abort in IDLE and DONE.
REQ-019 SHALL compute the next state in a combinational block and hold the state in a single register.

Reset
REQ-020 SHALL, with resetn=0, asynchronously force state=IDLE and layer_idx=0, all start pulses=0, done=0, error=0, cycle_count=0.
REQ-021 SHALL abandon any inference in progress when reset is asserted, and SHALL emit no pulse on release.
REQ-022 SHALL leave the FSM in IDLE on the first clock after reset release.

Configuration
REQ-030 SHALL compile the stage watchdog in only when macro NNSEQ_STAGE_TIMEOUT_EN is defined.
REQ-031 With the macro defined, SHALL count cycles spent in WAIT_DATA, MM, RELU and ARGMAX, restarting the count on every state entry.
- When the count reaches TIMEOUT_CYCLES, the FSM SHALL go to ERROR with error=1.
- In ERROR, start SHALL clear error and go to WAIT_DATA (same effects as REQ-006); abort SHALL clear error and go to IDLE.
REQ-032 Without the macro, SHALL tie error to 0, make ERROR unreachable, and instantiate no watchdog counter.

Verification
REQ-040 Happy path. Setup: NUM_LAYERS=4, cfg_k={784,64,64,32}, cfg_n={64,64,32,10}, every done returned 3 cycles after its start. Required response:
- 4 mm_start, 3 relu_start, 1 argmax_start, 1 done pulse.
- cur_k/cur_n sequence (784,64),(64,64),(64,32),(32,10).
REQ-041 NUM_LAYERS=1: start, data_ready -> mm_start, then argmax_start directly, no relu_start; done asserted.
REQ-042 Abort on the same cycle as mm_done during layer 2 -> state=IDLE next cycle; no relu_start, no done; cycle_count frozen.
REQ-043 Spurious inputs: start pulsed while in MM, and relu_done pulsed while in MM -> no state change and no extra start pulses.
REQ-044 With NNSEQ_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, mm_done withheld -> error=1 and state=ERROR 16 cycles after entering MM; a following start -> error=0, state=WAIT_DATA.
REQ-045 resetn pulsed low during RELU -> all outputs 0 and state=IDLE immediately; no pulse on release.
